// File: rtl/ham_ehb_decoder.sv
// Colour-resolve stage around ColourTable: issues CLUT reads per pixel and
// merges the returned colour with HAM hold-and-modify or EHB half-brite.
module ham_ehb_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_vld,
    input  logic [5:0]  pix_dat,
    input  logic        pix_brd,
    input  logic        ham_en,
    input  logic        ehb_en,
    output logic        clut_rd,
    output logic [4:0]  clut_idx,
    input  logic [11:0] clut_rgb,
    output logic        out_vld,
    output logic [11:0] out_rgb
);

    typedef enum logic [1:0] {
        MODE_NORM = 2'd0,
        MODE_EHB  = 2'd1,
        MODE_HAM  = 2'd2,
        MODE_BRD  = 2'd3
    } mode_e;

    typedef struct packed {
        logic       vld;
        mode_e      mode;
        logic [1:0] ctl;
        logic [3:0] dat;
    } side_t;

    mode_e       in_mode;
    side_t       s0;
    side_t       s1;
    side_t       s2;
    logic [11:0] hold_rgb;
    logic [11:0] res_rgb;

    always_comb begin
        in_mode = MODE_NORM;
        if (pix_brd)
            in_mode = MODE_BRD;
        else if (ham_en)
            in_mode = MODE_HAM;
        else if (ehb_en)
            in_mode = MODE_EHB;
    end

    // Request path is combinational so ColourTable samples it on the same edge as s1.
    always_comb begin
        clut_idx = pix_dat[4:0];
        clut_rd  = pix_vld;
        case (in_mode)
            MODE_BRD: clut_idx = 5'd0;
            MODE_HAM: begin
                clut_idx = {1'b0, pix_dat[3:0]};
                clut_rd  = pix_vld & (pix_dat[5:4] == 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        s0      = '0;
        s0.vld  = pix_vld;
        s0.mode = in_mode;
        s0.ctl  = pix_dat[5:4];
        s0.dat  = pix_dat[3:0];
    end

    // Sideband advances every clock, in lockstep with ColourTable's ungated read pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= s0;
            s2 <= s1;
        end
    end

    always_comb begin
        res_rgb = clut_rgb;
        case (s2.mode)
            MODE_EHB: begin
                if (s2.ctl[1])
                    res_rgb = {1'b0, clut_rgb[11:9], 1'b0, clut_rgb[7:5], 1'b0, clut_rgb[3:1]};
            end
            MODE_HAM: begin
                case (s2.ctl)
                    2'b01:   res_rgb = {hold_rgb[11:4], s2.dat};
                    2'b10:   res_rgb = {s2.dat, hold_rgb[7:0]};
                    2'b11:   res_rgb = {hold_rgb[11:8], s2.dat, hold_rgb[3:0]};
                    default: res_rgb = clut_rgb;
                endcase
            end
            default: res_rgb = clut_rgb;
        endcase
    end

    // The hold colour and the output pixel load under the same condition, so one
    // register serves both; bubbles leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            hold_rgb <= 12'h000;
        end else begin
            out_vld <= s2.vld;
            if (s2.vld)
                hold_rgb <= res_rgb;
        end
    end

    assign out_rgb = hold_rgb;

endmodule

// File: tb/tb_ham_ehb_decoder.sv
// Bench for ham_ehb_decoder: directed vector table, random pixels against a
// per-pixel colour model, and a mid-stream reset sequence.
module tb_ham_ehb_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_vld;
    logic [5:0]  pix_dat;
    logic        pix_brd;
    logic        ham_en;
    logic        ehb_en;
    logic        clut_rd;
    logic [4:0]  clut_idx;
    logic [11:0] clut_rgb;
    logic        out_vld;
    logic [11:0] out_rgb;

    ham_ehb_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_vld  (pix_vld),
        .pix_dat  (pix_dat),
        .pix_brd  (pix_brd),
        .ham_en   (ham_en),
        .ehb_en   (ehb_en),
        .clut_rd  (clut_rd),
        .clut_idx (clut_idx),
        .clut_rgb (clut_rgb),
        .out_vld  (out_vld),
        .out_rgb  (out_rgb)
    );

    always #5 clk = ~clk;

    // ColourTable stand-in: two-edge read latency, not reset.
    logic [11:0] clut [32];
    logic [11:0] ct_q1 = 12'h000;
    logic [11:0] ct_q2 = 12'h000;
    always @(posedge clk) begin
        ct_q1 <= clut[clut_idx];
        ct_q2 <= ct_q1;
    end
    assign clut_rgb = ct_q2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int          due;
        logic [11:0] rgb;
    } exp_t;
    exp_t        sb[$];
    logic [11:0] last_rgb = 12'h000;
    logic [11:0] m_hold   = 12'h000;

    typedef struct {
        logic        vld;
        logic [5:0]  dat;
        logic        brd;
        logic        ham;
        logic        ehb;
        logic [11:0] rgb;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] m_idx(input logic b, input logic h, input logic [5:0] d);
        if (b)      return 5'd0;
        else if (h) return {1'b0, d[3:0]};
        else        return d[4:0];
    endfunction

    function automatic logic m_rd(input logic v, input logic b, input logic h, input logic [5:0] d);
        return v && !(!b && h && d[5:4] != 2'b00);
    endfunction

    // Colour the pixel should get, from the mode rules and the previous valid pixel.
    function automatic logic [11:0] m_rgb(input logic b, input logic h, input logic e,
                                          input logic [5:0] d);
        logic [11:0] base;
        int r, g, bl, hr, hg, hb, nib;
        base = clut[m_idx(b, h, d)];
        r  = int'(base[11:8]);  g  = int'(base[7:4]);  bl = int'(base[3:0]);
        hr = int'(m_hold[11:8]); hg = int'(m_hold[7:4]); hb = int'(m_hold[3:0]);
        nib = int'(d[3:0]);
        if (b) return base;
        if (h) begin
            case (d[5:4])
                2'd1:    begin r = hr;  g = hg;  bl = nib; end
                2'd2:    begin r = nib; g = hg;  bl = hb;  end
                2'd3:    begin r = hr;  g = nib; bl = hb;  end
                default: ;
            endcase
        end else if (e && d[5]) begin
            r = r / 2; g = g / 2; bl = bl / 2;
        end
        return {r[3:0], g[3:0], bl[3:0]};
    endfunction

    task automatic drive(input logic v, input logic [5:0] d, input logic b, input logic h,
                         input logic e, input logic use_exp, input logic [11:0] exp_rgb);
        logic [11:0] m;
        exp_t        x;
        @(negedge clk);
        pix_vld = v; pix_dat = d; pix_brd = b; ham_en = h; ehb_en = e;
        #1;
        chk("clut_rd", {11'd0, clut_rd}, {11'd0, m_rd(v, b, h, d)});
        chk("clut_idx", {7'd0, clut_idx}, {7'd0, m_idx(b, h, d)});
        if (v) begin
            m = m_rgb(b, h, e, d);
            x.due = cyc + 3;
            x.rgb = use_exp ? exp_rgb : m;
            sb.push_back(x);
            m_hold = m;
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("out_vld", {11'd0, out_vld}, 12'd1);
                chk("out_rgb", out_rgb, sb[0].rgb);
                last_rgb = sb[0].rgb;
                void'(sb.pop_front());
            end else begin
                chk("out_vld_idle", {11'd0, out_vld}, 12'd0);
                chk("out_rgb_held", out_rgb, last_rgb);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        pix_vld = 1'b0; pix_dat = 6'h00; pix_brd = 1'b0; ham_en = 1'b0; ehb_en = 1'b0;
        for (int i = 0; i < 32; i++) clut[i] = 12'($urandom);
        clut[0] = 12'h0F0; clut[1] = 12'h123; clut[3] = 12'hFE7; clut[5] = 12'hA5C;

        vecs[0]  = '{1'b1, 6'h05, 1'b0, 1'b0, 1'b0, 12'hA5C};
        vecs[1]  = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[2]  = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[3]  = '{1'b1, 6'h23, 1'b0, 1'b0, 1'b1, 12'h773};
        vecs[4]  = '{1'b1, 6'h03, 1'b0, 1'b0, 1'b1, 12'hFE7};
        vecs[5]  = '{1'b1, 6'h01, 1'b0, 1'b1, 1'b0, 12'h123};
        vecs[6]  = '{1'b1, 6'h1F, 1'b0, 1'b1, 1'b0, 12'h12F};
        vecs[7]  = '{1'b1, 6'h2A, 1'b0, 1'b1, 1'b0, 12'hA2F};
        vecs[8]  = '{1'b1, 6'h35, 1'b0, 1'b1, 1'b0, 12'hA5F};
        vecs[9]  = '{1'b1, 6'h00, 1'b1, 1'b1, 1'b0, 12'h0F0};
        vecs[10] = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[11] = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[12] = '{1'b1, 6'h29, 1'b0, 1'b1, 1'b0, 12'h9F0};
        vecs[13] = '{1'b1, 6'h3C, 1'b0, 1'b1, 1'b1, 12'h9C0};
        vecs[14] = '{1'b1, 6'h3C, 1'b1, 1'b1, 1'b1, 12'h0F0};

        repeat (2) @(negedge clk);
        chk("reset_out_vld", {11'd0, out_vld}, 12'd0);
        chk("reset_out_rgb", out_rgb, 12'h000);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 15; i++)
            drive(vecs[i].vld, vecs[i].dat, vecs[i].brd, vecs[i].ham, vecs[i].ehb, 1'b1, vecs[i].rgb);

        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 9) < 7, 6'($urandom), $urandom_range(0, 9) == 0,
                  1'($urandom), 1'($urandom), 1'b0, 12'h000);

        // Two pixels in flight when reset hits.
        drive(1'b1, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        drive(1'b1, 6'h03, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        pix_vld = 1'b0; pix_dat = 6'h00; pix_brd = 1'b0; ham_en = 1'b0; ehb_en = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        last_rgb = 12'h000;
        m_hold   = 12'h000;
        #1;
        chk("async_rst_out_vld", {11'd0, out_vld}, 12'd0);
        chk("async_rst_out_rgb", out_rgb, 12'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        drive(1'b1, 6'h1A, 1'b0, 1'b1, 1'b0, 1'b1, 12'h00A);

        repeat (5) drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("scoreboard_drained", 12'(sb.size()), 12'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
